// File: rtl/chunked_adder_seq.sv
// Multi-cycle adder/subtractor. It adds CHUNK bits per clock, LSB chunk first,
// and keeps the inter-chunk carry in a register. A start/done handshake
// frames each operation. Subtract mode computes A + ~B + 1.
module chunked_adder_seq #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NUM_CHUNKS = WIDTH / CHUNK;
  localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int unsigned BASE_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  if ((CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
    $error("chunked_adder_seq: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [BASE_W-1:0]  base;
  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK:0]     chunk_sum;
  logic               msb_carry_in;

  // Chunk datapath, next-state logic and handshake outputs.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    ready   = 1'b0;
    done    = 1'b0;

    base         = BASE_W'(32'(idx_q) * CHUNK);
    a_chunk      = a_q[base +: CHUNK];
    b_chunk      = b_q[base +: CHUNK];
    chunk_sum    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    // The sum bit equals a ^ b ^ carry-in, so the carry into the MSB is recovered from it.
    msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];

    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d              = chunk_sum[CHUNK];
        idx_d                = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          // The result register takes the accumulator including this cycle's chunk.
          s_d     = acc_d;
          cout_d  = chunk_sum[CHUNK];
          ovf_d   = msb_carry_in ^ chunk_sum[CHUNK];
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_adder_seq.sv
// Bench for chunked_adder_seq: four instances (CHUNK = 8/16/32/64, WIDTH = 64)
// share one set of inputs and are checked every cycle against an arithmetic
// reference model.
module tb_chunked_adder_seq;

  localparam int NI = 4;
  localparam int W  = 64;
  localparam int CH [NI] = '{8, 16, 32, 64};
  localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] SMIN = -SMAX - 66'sd1;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [63:0] s;
    logic        c;
    logic        o;
  } vec_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cin   = 1'b0;
  logic        sub   = 1'b0;
  logic [63:0] a     = '0;
  logic [63:0] b     = '0;

  logic        ready_v [NI];
  logic        done_v  [NI];
  logic        cout_v  [NI];
  logic        ovf_v   [NI];
  logic [63:0] s_v     [NI];

  logic [63:0] prev_s    [NI];
  logic        prev_cout [NI];
  logic        prev_ovf  [NI];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    chunked_adder_seq #(.WIDTH(W), .CHUNK(CH[g])) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .sub   (sub),
      .ready (ready_v[g]),
      .done  (done_v[g]),
      .s     (s_v[g]),
      .cout  (cout_v[g]),
      .ovf   (ovf_v[g])
    );
  end

  task automatic check_eq(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // Returns {ovf, cout, s}: unsigned sum/difference and a signed range check.
  function automatic logic [65:0] golden(input logic [63:0] ga, input logic [63:0] gb,
                                         input logic gcin, input logic gsub);
    logic [64:0]        u;
    logic signed [65:0] sv;
    if (gsub) begin
      u  = {(ga >= gb), ga - gb};
      sv = $signed({{2{ga[63]}}, ga}) - $signed({{2{gb[63]}}, gb});
    end else begin
      u  = 65'(ga) + 65'(gb) + 65'(gcin);
      sv = $signed({{2{ga[63]}}, ga}) + $signed({{2{gb[63]}}, gb}) + $signed(66'(gcin));
    end
    return {(sv > SMAX) || (sv < SMIN), u};
  endfunction

  task automatic check_idle_zero(input string what);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("%s ready c%0d", what, CH[i]), 65'(ready_v[i]), 65'd1);
      check_eq($sformatf("%s done c%0d", what, CH[i]), 65'(done_v[i]), 65'd0);
      check_eq($sformatf("%s cout_s c%0d", what, CH[i]), {cout_v[i], s_v[i]}, 65'd0);
      check_eq($sformatf("%s ovf c%0d", what, CH[i]), 65'(ovf_v[i]), 65'd0);
      prev_s[i] = '0; prev_cout[i] = 1'b0; prev_ovf[i] = 1'b0;
    end
  endtask

  // One operation; j counts negedges after the accepting edge k.
  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_, input logic tcin,
                        input logic tsub, input logic [63:0] es, input logic ec,
                        input logic eo, input bit glitch, input string name);
    int n;
    @(negedge clk);
    a = ta; b = tb_; cin = tcin; sub = tsub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    cin = 1'($urandom); sub = 1'($urandom);
    for (int j = 0; j <= 10; j++) begin
      if (j > 0) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        n = W / CH[i];
        check_eq($sformatf("%s done c%0d j%0d", name, CH[i], j), 65'(done_v[i]), 65'(j == n));
        check_eq($sformatf("%s ready c%0d j%0d", name, CH[i], j), 65'(ready_v[i]), 65'(j > n));
        if (j < n) begin
          check_eq($sformatf("%s hold_s c%0d j%0d", name, CH[i], j),
                   {cout_v[i], s_v[i]}, {prev_cout[i], prev_s[i]});
          check_eq($sformatf("%s hold_ovf c%0d j%0d", name, CH[i], j),
                   65'(ovf_v[i]), 65'(prev_ovf[i]));
        end else begin
          check_eq($sformatf("%s cout_s c%0d j%0d", name, CH[i], j),
                   {cout_v[i], s_v[i]}, {ec, es});
          check_eq($sformatf("%s ovf c%0d j%0d", name, CH[i], j), 65'(ovf_v[i]), 65'(eo));
        end
      end
      if (glitch && j == 1) begin
        start = 1'b1; a = ~ta; b = tb_ ^ 64'h1234_5678; sub = ~tsub;
      end
      if (glitch && j == 2) start = 1'b0;
    end
    for (int i = 0; i < NI; i++) begin
      prev_s[i] = es; prev_cout[i] = ec; prev_ovf[i] = eo;
    end
  endtask

  // Reset asserted for one edge (k+2) while the multi-cycle instances are in RUN.
  task automatic reset_mid_run();
    @(negedge clk);
    a = 64'h0123_4567_89AB_CDEF; b = 64'h1111_2222_3333_4444; cin = 1'b1; sub = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_zero("midrst");
    for (int j = 3; j <= 11; j++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++)
        check_eq($sformatf("midrst nodone c%0d j%0d", CH[i], j), 65'(done_v[i]), 65'd0);
    end
  endtask

  vec_t dir [7];
  logic [65:0] g;
  logic [63:0] ra, rb;
  logic rc, rs;

  initial begin
    dir[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
    dir[1] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    dir[2] = '{64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0};
    dir[3] = '{64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    dir[4] = '{64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0};
    dir[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    dir[6] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++)
      run_op(dir[k].a, dir[k].b, dir[k].cin, dir[k].sub, dir[k].s, dir[k].c, dir[k].o,
             1'b0, $sformatf("dir%0d", k));

    // A second start during RUN must be dropped; the first result stands.
    run_op(64'h0000_0000_FFFF_0000, 64'h0000_0001_0001_0000, 1'b0, 1'b0,
           64'h0000_0002_0000_0000, 1'b0, 1'b0, 1'b1, "glitch");

    reset_mid_run();
    run_op(64'h1234, 64'h4321, 1'b1, 1'b0, 64'h5556, 1'b0, 1'b0, 1'b0, "after_rst");

    for (int k = 0; k < 1000; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ra = '1;
        1: ra = 64'h7FFF_FFFF_FFFF_FFFF;
        2: rb = 64'h8000_0000_0000_0000;
        3: rb = ra;
        default: ;
      endcase
      rc = 1'($urandom);
      rs = 1'($urandom);
      g  = golden(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, g[63:0], g[64], g[65], (k % 50) == 7, $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
